// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master FSM states, R/W bit values and
// quarter-phase codes used by the master, slave and read-master blocks.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_DATA,
        ST_DATA_ACK,
        ST_STOP
    } i2c_state_e;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } i2c_quarter_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_phase_gen.sv
// CLK_DIV prescaler producing the quarter-phase index of an SCL bit period
// and a one-cycle tick on the last clk of each quarter.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    output logic [1:0] q,
    output logic       phase_tick
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  q_q, q_d;

    always_comb begin
        phase_tick = (cnt_q == LAST);
        cnt_d      = phase_tick ? 16'd0 : cnt_q + 16'd1;
        q_d        = phase_tick ? q_q + 2'd1 : q_q;
        if (clear) begin
            cnt_d = 16'd0;
            q_d   = Q0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
            q_q   <= Q0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C write master: START, address+W, ACK, data, ACK, STOP.
// SCL is derived from clk; SDA is open-drain and only ever pulled low.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    i2c_state_e state_q, state_d;
    logic [7:0] tx_byte_q, tx_byte_d;
    logic [7:0] data_q, data_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       sda_oe_q, sda_oe_d;
    logic       nack_q, nack_d;
    logic       ack_err_q, ack_err_d;
    logic       done_q, done_d;
    logic       first_q;

    logic [1:0] q;
    logic       phase_tick;
    logic       end_q0, end_q1, end_q2, end_q3;
    logic       cur_bit;
    logic       scl_o;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == ST_IDLE),
        .q          (q),
        .phase_tick (phase_tick)
    );

    assign end_q0  = phase_tick && (q == Q0);
    assign end_q1  = phase_tick && (q == Q1);
    assign end_q2  = phase_tick && (q == Q2);
    assign end_q3  = phase_tick && (q == Q3);
    assign cur_bit = (state_q == ST_DATA) ? data_q[bit_cnt_q]
                                          : tx_byte_q[bit_cnt_q];

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        data_d    = data_q;
        bit_cnt_d = bit_cnt_q;
        sda_oe_d  = sda_oe_q;
        nack_d    = nack_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        scl_o     = 1'b1;
        // First clk of q3 is the ACK sample point; anything but 0 is NACK.
        if (first_q && (q == Q3)) begin
            if (sda == 1'b0) nack_d = 1'b0;
            else             nack_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                sda_oe_d = 1'b0;
                if (start && !done_q) begin
                    tx_byte_d = {slave_addr, I2C_WRITE};
                    data_d    = data_in;
                    ack_err_d = 1'b0;
                    bit_cnt_d = 3'd7;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (end_q1) sda_oe_d = 1'b1;
                if (end_q3) state_d = ST_ADDR;
            end
            ST_ADDR, ST_DATA: begin
                scl_o = q[1];
                if (end_q0) sda_oe_d = ~cur_bit;
                if (end_q3) begin
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK
                                                       : ST_DATA_ACK;
                    end
                end
            end
            ST_ADDR_ACK: begin
                scl_o = q[1];
                if (end_q0) sda_oe_d = 1'b0;
                if (end_q3) begin
                    if (nack_q) begin
                        ack_err_d = 1'b1;
                        sda_oe_d  = 1'b1;
                        state_d   = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA_ACK: begin
                scl_o = q[1];
                if (end_q0) sda_oe_d = 1'b0;
                if (end_q3) begin
                    if (nack_q) ack_err_d = 1'b1;
                    sda_oe_d = 1'b1;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                scl_o = q[1];
                if (end_q2) sda_oe_d = 1'b0;
                if (end_q3) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tx_byte_q <= 8'd0;
            data_q    <= 8'd0;
            bit_cnt_q <= 3'd7;
            sda_oe_q  <= 1'b0;
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_byte_q <= tx_byte_d;
            data_q    <= data_d;
            bit_cnt_q <= bit_cnt_d;
            sda_oe_q  <= sda_oe_d;
            nack_q    <= nack_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            first_q   <= phase_tick;
        end
    end

    assign sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign scl     = scl_o;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: behavioural slave on the bus plus a
// transaction-level model of expected bytes, latency and ack_err.
module tb_i2c_master_controller;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] slave_addr = 7'd0;
    logic [7:0] data_in = 8'd0;
    logic       busy, done, ack_err, scl;
    wire        sda;

    logic       drv = 1'b0;
    logic       pres = 1'b1;
    logic       dack = 1'b1;
    logic [6:0] tgt = 7'h42;
    logic       mon_en = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    pullup (sda);
    assign sda = drv ? 1'b0 : 1'bz;

    i2c_master_controller #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .slave_addr (slave_addr),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .scl        (scl),
        .sda        (sda)
    );

    always #5 clk = ~clk;

    function automatic logic sda_v();
        return (sda === 1'b0) ? 1'b0 : 1'b1;
    endfunction

    // Behavioural slave and bus monitor, sampled away from the active edge.
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       sb;
    logic       in_x = 1'b0;
    logic       ack_ph = 1'b0;
    logic [7:0] sh = 8'd0;
    int         bitn = 0;
    int         byten = 0;
    int         hi_falls = 0;
    int         hi_rises = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        sb = sda_v();
        if (rst) begin
            in_x = 1'b0; ack_ph = 1'b0; drv = 1'b0;
            bitn = 0; byten = 0;
        end else begin
            if (mon_en && p_scl && scl) begin
                if (p_sda && !sb) hi_falls++;
                if (!p_sda && sb) hi_rises++;
            end
            if (p_scl && scl && p_sda && !sb) begin
                in_x = 1'b1; ack_ph = 1'b0; bitn = 0; byten = 0;
            end else if (p_scl && scl && !p_sda && sb) begin
                in_x = 1'b0; drv = 1'b0;
            end else if (in_x && !p_scl && scl && !ack_ph) begin
                sh = {sh[6:0], sb};
                bitn++;
            end else if (in_x && p_scl && !scl) begin
                if (ack_ph) begin
                    drv = 1'b0; ack_ph = 1'b0;
                end else if (bitn == 8) begin
                    rx_q.push_back(sh);
                    ack_ph = 1'b1;
                    bitn = 0;
                    drv = (byten == 0) ? (pres && sh == {tgt, 1'b0}) : dack;
                    byten++;
                end
            end
        end
        p_scl = scl;
        p_sda = sb;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic [6:0] a,
                       input logic [7:0] d, input logic p,
                       input logic da, input logic hold);
        logic       aack;
        logic [7:0] exp_b[$];
        int         lat, n, f0, r0, q0;
        aack = p && (a == tgt);
        exp_b.delete();
        exp_b.push_back({a, 1'b0});
        if (aack) exp_b.push_back(d);
        lat  = (aack ? 80 : 44) * DIV;
        pres = p; dack = da; mon_en = 1'b1;
        @(negedge clk);
        f0 = hi_falls; r0 = hi_rises; q0 = rx_q.size();
        slave_addr = a; data_in = d; start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy"}, busy, 1);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
            slave_addr = 7'($urandom);
            data_in = 8'($urandom);
        end
        n = 0;
        while (n < 100 * DIV) begin
            @(posedge clk); n++; #1;
            if (done) break;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_ackerr"}, ack_err, !aack || !da);
        chk({tag, "_scl_idle"}, scl, 1);
        chk({tag, "_sda_idle"}, sda_v(), 1);
        chk({tag, "_nbytes"}, rx_q.size() - q0, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (q0 + i < rx_q.size())
                chk({tag, "_byte"}, rx_q[q0 + i], exp_b[i]);
        chk({tag, "_start_edges"}, hi_falls - f0, 1);
        chk({tag, "_stop_edges"}, hi_rises - r0, 1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_ackerr_held"}, ack_err, !aack || !da);
    endtask

    initial begin
        int n;
        logic [6:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ackerr", ack_err, 0);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda_v(), 1);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        tgt = 7'h42;
        run("full", 7'h42, 8'hA5, 1'b1, 1'b1, 1'b0);
        run("addr_nack", 7'h42, 8'hA5, 1'b0, 1'b1, 1'b0);
        run("data_nack", 7'h42, 8'h3C, 1'b1, 1'b0, 1'b0);

        // start held through the whole transfer and its done cycle
        run("hold", 7'h42, 8'h5A, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("hold_reaccept", busy, 1);
        chk("hold_ackerr_clr", ack_err, 0);
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 100 * DIV && !done) begin @(posedge clk); n++; #1; end
        chk("hold_second_done", done, 1);
        chk("hold_second_err", ack_err, 1);
        repeat (2) @(negedge clk);

        // reset in the middle of the 4th data bit
        mon_en = 1'b0; pres = 1'b1; dack = 1'b1; tgt = 7'h42;
        @(negedge clk); slave_addr = 7'h42; data_in = 8'h00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(byten == 1 && bitn == 3) && n < 200 * DIV) begin
            @(negedge clk); n++;
        end
        chk("rst_mid_reach", (byten == 1 && bitn == 3), 1);
        repeat (3 * DIV) @(negedge clk);
        chk("rst_mid_pre_sda", sda_v(), 0);
        chk("rst_mid_pre_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_scl", scl, 1);
        chk("rst_mid_sda", sda_v(), 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_ackerr", ack_err, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        run("post_rst", 7'h42, 8'hC3, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            tgt = 7'($urandom);
            a = ($urandom_range(0, 3) != 0) ? tgt : 7'($urandom);
            run("rand", a, 8'($urandom), 1'($urandom_range(0, 5) != 0),
                1'($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_master_controller.md
Name: i2c_master_controller

Overview:
- Single-byte I2C write master; the initiating end for the team's I2C slave receivers.
- On a `start` request it generates START, sends the 7-bit address plus W (0), and checks the ACK.
- If the address is acknowledged, it sends one data byte, checks the ACK, then generates STOP.
- Sits between the system-clock control logic and the on-board I2C bus; derives SCL from `clk`.

Parameters:
- CLK_DIV, 250: `clk` cycles per quarter-SCL phase; SCL period = 4*CLK_DIV cycles; legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  transaction request; sampled only in IDLE.
- slave_addr  input  7  target address; latched when start is accepted.
- data_in  input  8  byte to write; latched when start is accepted.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at transaction end.
- ack_err  output  1  NACK seen (address or data); valid with done, held until next accepted start.
- scl  output  1  bus clock, push-pull; idle high.
- sda  inout  1  open-drain: driven 0 or released to 'z; never driven 1.

Behaviour:
- Reset (any state, mid-transfer included): next cycle scl=1, sda released, busy=0, done=0, ack_err=0, state=IDLE, phase counters cleared. No STOP is generated on reset.
- Timing base:
  - CLK_DIV counter produces quarter phases q0..q3; one bit period = q0..q3.
  - Data periods: scl=0 in q0/q1 and 1 in q2/q3.
  - SDA changes only at the start of q1, so hold time after the SCL fall is CLK_DIV cycles.
  - ACK is sampled on the first clk of q3; sda==0 means ACK, anything else (1/z) means NACK.
- States and transitions:
  - IDLE: scl=1, sda released. If start=1, latch tx_byte={slave_addr,1'b0} and data, clear ack_err, go to START.
  - START (1 period): scl=1 throughout; sda released q0-q1, driven low q2-q3.
  - ADDR (8 periods): MSB first from tx_byte.
  - ADDR_ACK (1 period): sda released. On ACK go to DATA; on NACK set ack_err=1 and go to STOP.
  - DATA (8 periods): MSB first from the latched data.
  - DATA_ACK (1 period): sda released; on NACK set ack_err=1; always go to STOP.
  - STOP (1 period): scl=0 in q0-q1 and 1 in q2-q3; sda low in q0-q2, released at the start of q3.
  - After STOP, return to IDLE and pulse done for 1 cycle.
- Bit counter: 3 bits, counts 7 down to 0; the state change happens at the end of the q3 in which the count is 0.
- Latency, measured from the start-accept cycle to the done pulse:
  - Full transfer: 20 periods = 80*CLK_DIV cycles.
  - Address NACK: 11 periods = 44*CLK_DIV cycles.
- Busy and done timing:
  - start is ignored while busy.
  - start asserted in the done cycle is ignored; it is accepted from the next IDLE cycle.
- slave_addr and data_in may change after acceptance without effect.

Decomposition:
- Shared package/header i2c_pkg:
  - State encodings (IDLE..STOP).
  - I2C_WRITE=1'b0 and I2C_READ=1'b1.
  - Quarter-phase encodings; these are shared with future slave and read-master blocks.
- One sub-module, i2c_phase_gen: CLK_DIV prescaler. Outputs quarter-phase index q[1:0] and a one-cycle phase_tick; it is cleared by rst and held in reset while the master is in IDLE.

Test Plan:
- CLK_DIV=4, slave model ACKs address 0x42: write 0xA5 -> SDA bits sampled at SCL rise are 1000010,0 then 10100101; done at cycle 320 after accept; ack_err=0; STOP is SDA rising while scl=1.
- No slave at 0x42 (sda stays 'z) -> ack_err=1; no data bits clocked; done at cycle 176; bus ends scl=1, sda released.
- Slave ACKs address but NACKs data -> all 8 data bits sent, ack_err=1, STOP issued, done at cycle 320.
- start pulsed repeatedly while busy, and in the done cycle -> exactly one transaction; a new start the following cycle is accepted and ack_err clears.
- rst asserted during the 4th DATA bit -> next cycle scl=1, sda released, busy=0; a subsequent start produces a clean full transfer.
- Hold and glitch check: in all data periods SDA never changes while scl=1, except the START and STOP edges.
